scrambler_param: RTL

SCRAMBLER_PARAM -- requirements
Module: scrambler_param

---
 rtl/scrambler_param.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/scrambler_param.sv
// Self-synchronous scrambler or descrambler for the 1 + x^39 + x^58 polynomial. Each cycle it
// processes one DATA_WIDTH-bit word, bit 0 first on the line.
//
// Parameters:
//   DATA_WIDTH  word width: 16, 32 or 64
//   DESCRAMBLE  0 = scrambler, 1 = descrambler
//   OUTPUT_REG  1 = outputs registered (1-cycle latency), 0 = combinational (same cycle)
//
// Ports:
//   i_clk        clock
//   i_reset      synchronous active-high reset
//   i_init_done  transceiver ready; while low the block is held in reset
//   i_valid      i_data present this cycle
//   i_bypass     pass i_data through unchanged and freeze the scrambler state
//   i_data       input word
//   o_valid      o_data present this cycle
//   o_data       processed word
//   o_sync       o_data was computed from a fully flushed state
module scrambler_param #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DESCRAMBLE = 0,
  parameter int unsigned OUTPUT_REG = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_init_done,
  input  logic                  i_valid,
  input  logic                  i_bypass,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_sync
);

  localparam int unsigned StateW  = 58;
  localparam int unsigned TapA    = 39;
  localparam int unsigned HistW   = StateW + DATA_WIDTH;
  localparam int unsigned SyncCnt = (StateW + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam logic [2:0]  SyncCntL = 3'(SyncCnt);

  if (DATA_WIDTH != 16 && DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : gen_bad_width
    $error("scrambler_param: DATA_WIDTH must be 16, 32 or 64");
  end
  if (DESCRAMBLE > 1) begin : gen_bad_mode
    $error("scrambler_param: DESCRAMBLE must be 0 or 1");
  end
  if (OUTPUT_REG > 1) begin : gen_bad_oreg
    $error("scrambler_param: OUTPUT_REG must be 0 or 1");
  end

  // Line-side history in time order: h[p] holds line bit L(p - 58). The lower 58 entries come
  // from the state (oldest first); the upper DATA_WIDTH entries are this word's line bits, built
  // LSB first so that taps landing inside the current word see already-computed bits.
  function automatic logic [HistW-1:0] build_hist(input logic [StateW-1:0] s,
                                                   input logic [DATA_WIDTH-1:0] d);
    logic [HistW-1:0] h;
    logic             b;
    h = '0;
    for (int p = 0; p < StateW; p++) begin
      h[p] = s[StateW-1-p];
    end
    for (int i = 0; i < DATA_WIDTH; i++) begin
      b = d[i] ^ h[i+StateW-TapA] ^ h[i];
      h[i+StateW] = (DESCRAMBLE != 0) ? d[i] : b;
    end
    return h;
  endfunction

  logic [StateW-1:0]     state_q, state_d, state_shift;
  logic [2:0]            cnt_q, cnt_d;
  logic [HistW-1:0]      hist;
  logic [DATA_WIDTH-1:0] proc_word;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_sync;
  logic                  accept;
  logic                  hold;

  assign hold   = i_reset | ~i_init_done;
  assign accept = i_valid & ~i_bypass;

  always_comb begin
    hist        = build_hist(state_q, i_data);
    proc_word   = '0;
    state_shift = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      proc_word[i] = i_data[i] ^ hist[i+StateW-TapA] ^ hist[i];
    end
    // Newest line bit lands in S[0].
    for (int k = 0; k < StateW; k++) begin
      state_shift[k] = hist[HistW-1-k];
    end
  end

  always_comb begin
    state_d  = accept ? state_shift : state_q;
    cnt_d    = (accept && cnt_q != SyncCntL) ? cnt_q + 3'd1 : cnt_q;
    out_data = i_bypass ? i_data : proc_word;
    // A scrambler's output never depends on an unknown state; a descrambler needs N words.
    out_sync = (DESCRAMBLE != 0) ? (cnt_q == SyncCntL) : 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (hold) begin
      state_q <= '1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  if (OUTPUT_REG != 0) begin : gen_out_reg
    logic                  valid_q;
    logic                  sync_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge i_clk) begin
      if (hold) begin
        valid_q <= 1'b0;
        sync_q  <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= i_valid;
        if (i_valid) begin
          data_q <= out_data;
          sync_q <= out_sync;
        end
      end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_sync  = sync_q;
  end else begin : gen_out_comb
    always_comb begin
      o_valid = i_valid & ~hold;
      o_data  = o_valid ? out_data : '0;
      o_sync  = o_valid & out_sync;
    end
  end

endmodule
